// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB next-PC predictor with execute-side mispredict resolver
// Defining RAS_PREDICT_EN adds a return-address stack for return prediction.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W       = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic            stall,
  input  logic            f_valid,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_valid,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            r_valid,
  input  logic [XLEN-1:0] r_pc,
  input  logic [1:0]      r_type,
  input  logic            r_taken,
  input  logic [XLEN-1:0] r_target,
  input  logic            r_link,
  input  logic            r_ret,
  input  logic            r_pred_taken,
  input  logic [XLEN-1:0] r_pred_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
);
  localparam int         IW       = $clog2(BTB_ENTRIES);
  localparam logic [1:0] T_BRANCH = 2'b01;

  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [XLEN-3:0]  tgt_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];

  logic            p_valid_q, p_taken_q, flush_q;
  logic [XLEN-1:0] p_target_q, redirect_q;
  logic            p_taken_d;
  logic [XLEN-1:0] p_target_d, redirect_d;

  logic [IW-1:0]    l_idx, r_idx;
  logic [TAG_W-1:0] l_tag, r_tag;
  logic             l_hit, r_hit, l_taken;
  logic [XLEN-1:0]  l_target;

  logic       resolve_en, actual, mispredict, wr_en;
  logic [1:0] wr_ctr;

  assign l_idx = f_pc[IW+1:2];
  assign l_tag = f_pc[IW+TAG_W+1:IW+2];
  assign r_idx = r_pc[IW+1:2];
  assign r_tag = r_pc[IW+TAG_W+1:IW+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

  assign resolve_en = r_valid && (r_type != 2'b00);
  assign actual     = (r_type == T_BRANCH) ? r_taken : 1'b1;
  assign mispredict = (r_pred_taken != actual) || (actual && (r_pred_target != r_target));
  assign redirect_d = actual ? r_target : r_pc + XLEN'(4);

`ifdef RAS_PREDICT_EN
  localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int PW = $clog2(RAS_DEPTH + 1);

  logic            ret_q [BTB_ENTRIES];
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d, ras_pop_ptr;
  logic [RW-1:0]   ras_top_idx;
  logic [XLEN-1:0] ras_top;
  logic            ras_full_push;

  // ras_ptr_q counts live entries; an empty stack still exposes slot 0 as its stale top.
  always_comb begin
    ras_top_idx   = (ras_ptr_q == '0) ? '0 : RW'(ras_ptr_q - PW'(1));
    ras_top       = ras_q[ras_top_idx];
    ras_pop_ptr   = ras_ptr_q;
    if (resolve_en && r_ret && (ras_ptr_q != '0)) ras_pop_ptr = ras_ptr_q - PW'(1);
    ras_ptr_d     = ras_pop_ptr;
    ras_full_push = 1'b0;
    if (resolve_en && r_link) begin
      if (ras_pop_ptr == PW'(RAS_DEPTH)) ras_full_push = 1'b1;
      else ras_ptr_d = ras_pop_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rstB) begin
    if (rstB) begin
      ras_ptr_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      if (resolve_en && r_link) begin
        if (ras_full_push) begin
          for (int i = 0; i < RAS_DEPTH - 1; i++) ras_q[i] <= ras_q[i+1];
          ras_q[RAS_DEPTH-1] <= r_pc + XLEN'(4);
        end else begin
          ras_q[RW'(ras_pop_ptr)] <= r_pc + XLEN'(4);
        end
      end
    end
  end
`else
  logic unused_ras;
  assign unused_ras = r_link ^ r_ret;
`endif

  always_comb begin
    l_taken  = l_hit && ctr_q[l_idx][1];
    l_target = {tgt_q[l_idx], 2'b00};
`ifdef RAS_PREDICT_EN
    if (l_hit && ret_q[l_idx]) begin
      l_taken  = 1'b1;
      l_target = ras_top;
    end
`endif
    p_taken_d  = f_valid && l_taken;
    p_target_d = l_taken ? l_target : f_pc + XLEN'(4);
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_ctr = (r_type == T_BRANCH) ? 2'b10 : 2'b11;
    if (resolve_en) begin
      if (r_hit) begin
        wr_en = 1'b1;
        if (r_type == T_BRANCH) begin
          if (actual) wr_ctr = (ctr_q[r_idx] == 2'b11) ? 2'b11 : ctr_q[r_idx] + 2'b01;
          else        wr_ctr = (ctr_q[r_idx] == 2'b00) ? 2'b00 : ctr_q[r_idx] - 2'b01;
        end
      end else if (actual) begin
        wr_en = 1'b1;
      end
    end
  end

  // Lookup reads the _q arrays before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or posedge rstB) begin
    if (rstB) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
`ifdef RAS_PREDICT_EN
        ret_q[i]   <= 1'b0;
`endif
      end
      p_valid_q  <= 1'b0;
      p_taken_q  <= 1'b0;
      p_target_q <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      if (!stall) begin
        p_valid_q  <= f_valid;
        p_taken_q  <= p_taken_d;
        p_target_q <= p_target_d;
      end
      flush_q <= resolve_en && mispredict;
      if (resolve_en && mispredict) redirect_q <= redirect_d;
      if (wr_en) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
        tgt_q[r_idx]   <= r_target[XLEN-1:2];
        ctr_q[r_idx]   <= wr_ctr;
`ifdef RAS_PREDICT_EN
        ret_q[r_idx]   <= r_ret;
`endif
      end
    end
  end

  assign p_valid     = p_valid_q;
  assign p_taken     = p_taken_q;
  assign p_target    = p_target_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed bench for branch_predict_unit with a table-level reference model
// RAS scenarios run only when RAS_PREDICT_EN is defined.
module tb_branch_predict_unit;
  localparam int N  = 16;
  localparam int TW = 8;
  localparam int RD = 4;
  localparam logic [1:0] BR = 2'b01, JAL = 2'b10, JALR = 2'b11;

  logic        clk = 1'b0;
  logic        rstB = 1'b1;
  logic        stall, f_valid, r_valid, r_taken, r_link, r_ret, r_pred_taken;
  logic [31:0] f_pc, r_pc, r_target, r_pred_target;
  logic [1:0]  r_type;
  logic        p_valid, p_taken, flush;
  logic [31:0] p_target, redirect_pc;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(N), .TAG_W(TW), .RAS_DEPTH(RD)) dut (
    .clk(clk), .rstB(rstB), .stall(stall),
    .f_valid(f_valid), .f_pc(f_pc),
    .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
    .r_valid(r_valid), .r_pc(r_pc), .r_type(r_type), .r_taken(r_taken),
    .r_target(r_target), .r_link(r_link), .r_ret(r_ret),
    .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of entries addressed by word index, plus a list-based return stack.
  bit          mv   [N];
  int unsigned mtag [N];
  logic [31:0] mtgt [N];
  int          mctr [N];
  bit          mret [N];
  logic [31:0] ras [$];
  logic [31:0] stale;
  logic        exp_pv, exp_pt, exp_fl;
  logic [31:0] exp_ptgt, exp_rd;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return ((pc >> 2) / N) % (1 << TW);
  endfunction

  always @(posedge clk or posedge rstB) begin : model
    int unsigned li, ri;
    bit          hit, act, tk;
    logic [31:0] tg, popv;
    if (rstB) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 1; mret[i] = 0;
      end
      ras.delete();
      stale = 0;
      exp_pv = 0; exp_pt = 0; exp_ptgt = 0; exp_fl = 0; exp_rd = 0;
    end else begin
      if (!stall) begin
        li  = idx_of(f_pc);
        hit = mv[li] && (mtag[li] == tag_of(f_pc));
        tk  = hit && (mctr[li] >= 2);
        tg  = mtgt[li];
`ifdef RAS_PREDICT_EN
        if (hit && mret[li]) begin
          tk = 1;
          tg = (ras.size() > 0) ? ras[$] : stale;
        end
`endif
        exp_pv   = f_valid;
        exp_pt   = f_valid && tk;
        exp_ptgt = tk ? tg : f_pc + 32'd4;
      end
      exp_fl = 0;
      if (r_valid && r_type != 2'b00) begin
        act = (r_type == BR) ? r_taken : 1'b1;
        if ((r_pred_taken != act) || (act && r_pred_target != r_target)) begin
          exp_fl = 1;
          exp_rd = act ? r_target : r_pc + 32'd4;
        end
        ri  = idx_of(r_pc);
        hit = mv[ri] && (mtag[ri] == tag_of(r_pc));
        if (hit) begin
          if (r_type == BR) mctr[ri] = act ? ((mctr[ri] == 3) ? 3 : mctr[ri] + 1)
                                           : ((mctr[ri] == 0) ? 0 : mctr[ri] - 1);
          else mctr[ri] = 3;
          mtgt[ri] = r_target;
          mret[ri] = r_ret;
        end else if (act) begin
          mv[ri] = 1; mtag[ri] = tag_of(r_pc); mtgt[ri] = r_target;
          mctr[ri] = (r_type == BR) ? 2 : 3;
          mret[ri] = r_ret;
        end
`ifdef RAS_PREDICT_EN
        if (r_ret && ras.size() > 0) begin
          popv = ras.pop_back();
          if (ras.size() == 0) stale = popv;
        end
        if (r_link) begin
          ras.push_back(r_pc + 32'd4);
          if (ras.size() > RD) void'(ras.pop_front());
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("p_valid", {31'd0, p_valid}, {31'd0, exp_pv});
      if (exp_pv) begin
        chk("p_taken", {31'd0, p_taken}, {31'd0, exp_pt});
        chk("p_target", p_target, exp_ptgt);
      end
      chk("flush", {31'd0, flush}, {31'd0, exp_fl});
      if (exp_fl) chk("redirect_pc", redirect_pc, exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; f_valid = 0; f_pc = 0;
    r_valid = 0; r_pc = 0; r_type = 2'b00; r_taken = 0; r_target = 0;
    r_link = 0; r_ret = 0; r_pred_taken = 0; r_pred_target = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    f_valid = 1; f_pc = pc;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic lnk, input logic rt);
    r_valid = 1; r_pc = pc; r_type = ty; r_taken = tk; r_target = tgt;
    r_pred_taken = ptk; r_pred_target = ptgt; r_link = lnk; r_ret = rt;
  endtask

  task automatic lit_p(input string name, input logic tk, input logic [31:0] tgt);
    chk({name, "_valid"}, {31'd0, p_valid}, 32'd1);
    chk({name, "_taken"}, {31'd0, p_taken}, {31'd0, tk});
    chk({name, "_target"}, p_target, tgt);
  endtask

  task automatic lit_f(input string name, input logic fl, input logic [31:0] rd);
    chk({name, "_flush"}, {31'd0, flush}, {31'd0, fl});
    if (fl) chk({name, "_redirect"}, redirect_pc, rd);
  endtask

  initial begin
    idle();
    rstB = 1;
    tick();
    check_en = 1;
    tick();
    chk("rst_p_valid", {31'd0, p_valid}, 32'd0);
    chk("rst_p_target", p_target, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    lit_f("rst", 1'b0, 32'd0);
    rstB = 0;

    lookup(32'h100); tick();
    lit_p("cold", 1'b0, 32'h104);

    idle(); resolve(32'h100, BR, 1, 32'h80, 0, 32'h0, 0, 0); tick();
    lit_f("alloc", 1'b1, 32'h80);
    idle(); lookup(32'h100); tick();
    lit_p("after_alloc", 1'b1, 32'h80);
    lit_f("no_flush", 1'b0, 32'h0);

    idle(); resolve(32'h100, BR, 0, 32'h80, 1, 32'h80, 0, 0); tick();
    lit_f("nt1", 1'b1, 32'h104);
    tick();
    lit_f("nt2", 1'b1, 32'h104);
    idle(); lookup(32'h100); tick();
    lit_p("ctr_low", 1'b0, 32'h104);

    idle(); resolve(32'h100, JAL, 0, 32'h80, 0, 32'h0, 0, 0); tick();
    lit_f("jal", 1'b1, 32'h80);
    idle(); lookup(32'h100 + 4 * N * (1 << TW)); tick();
    lit_p("tag_alias", 1'b1, 32'h80);
    idle(); lookup(32'h100 + 4 * N); tick();
    lit_p("idx_alias", 1'b0, 32'h144);

    idle(); lookup(32'h100); resolve(32'h140, BR, 1, 32'h300, 0, 32'h0, 0, 0); tick();
    lit_p("rbw_old", 1'b1, 32'h80);
    lit_f("rbw", 1'b1, 32'h300);
    idle(); lookup(32'h100); tick();
    lit_p("evicted", 1'b0, 32'h104);
    idle(); lookup(32'h140); tick();
    lit_p("new_entry", 1'b1, 32'h300);

    idle(); stall = 1; lookup(32'h200); resolve(32'h140, JALR, 1, 32'h380, 1, 32'h300, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit_p("stall", 1'b1, 32'h300);
      if (i == 0) begin
        lit_f("stall_tgt", 1'b1, 32'h380);
        r_valid = 0; r_type = 2'b00;
      end else begin
        lit_f("stall_quiet", 1'b0, 32'h0);
      end
    end

    idle(); lookup(32'hFFFF_FFFC); resolve(32'hFFFF_FFFC, BR, 0, 32'h0, 1, 32'h40, 0, 0); tick();
    lit_p("wrap", 1'b0, 32'h0);
    lit_f("wrap", 1'b1, 32'h0);
    idle(); lookup(32'h140); tick();
    lit_p("jalr_tgt", 1'b1, 32'h380);

    idle(); resolve(32'h140, BR, 0, 32'h0, 1, 32'h380, 0, 0); tick();
    lit_f("pre_rst", 1'b1, 32'h144);
    idle();
    #1 rstB = 1;
    #1 chk("async_flush", {31'd0, flush}, 32'd0);
    chk("async_p_target", p_target, 32'd0);
    tick();
    rstB = 0;
    lookup(32'h140); tick();
    lit_p("post_rst", 1'b0, 32'h144);

`ifdef RAS_PREDICT_EN
    idle(); resolve(32'h200, JAL, 1, 32'h600, 1, 32'h600, 1, 0); tick();
    lit_f("call", 1'b0, 32'h0);
    idle(); resolve(32'h300, JALR, 1, 32'h204, 0, 32'h0, 0, 1); tick();
    lit_f("ret", 1'b1, 32'h204);
    idle(); lookup(32'h300); tick();
    lit_p("ras_ret", 1'b1, 32'h204);
    for (int k = 0; k < 5; k++) begin
      idle(); resolve(32'h1004 + 32'(4 * k), JAL, 1, 32'h2000, 1, 32'h2000, 1, 0); tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle(); lookup(32'h300);
      resolve(32'h300, JALR, 1, 32'h1018 - 32'(4 * k), 1, 32'h1018 - 32'(4 * k), 0, 1);
      tick();
      lit_p("ras_lifo", 1'b1, 32'h1018 - 32'(4 * k));
    end
`endif

    idle(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised fetch-side branch predictor and execute-side resolver for the RV32I core; successor to the fixed single-cycle branch/jump handler. Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Predicts next-PC one cycle after a fetch lookup. On resolution in execute, compares prediction with outcome and raises a registered flush/redirect. Sits between PC generation (fetch) and the ALU/compare stage.

## Interface
- `XLEN`, 32, address/data width
- `BTB_ENTRIES`, 16, BTB depth; power of 2, ≥2; index `IW = log2(BTB_ENTRIES)`
- `TAG_W`, 8, tag bits stored per entry
- `RAS_DEPTH`, 4, return-address-stack depth (used only with `RAS_PREDICT_EN`)

Ports:
- `clk` in 1 — single clock, rising edge
- `rstB` in 1 — reset, asynchronous, active-high (1 = reset)
- `stall` in 1 — freezes prediction output registers
- `f_valid` in 1 — fetch lookup request
- `f_pc` in XLEN — fetch PC
- `p_valid` out 1 — prediction valid (registered)
- `p_taken` out 1 — predicted taken
- `p_target` out XLEN — predicted next PC (target if taken, else `f_pc+4`)
- `r_valid` in 1 — resolved control-flow instruction present
- `r_pc` in XLEN — PC of resolved instruction
- `r_type` in 2 — 00 none, 01 branch, 10 jal, 11 jalr
- `r_taken` in 1 — actual direction (ignored/forced 1 for jal/jalr)
- `r_target` in XLEN — actual target, bit 0 already cleared by caller
- `r_link` in 1 — rd is x1/x5 (call)
- `r_ret` in 1 — jalr with rs1 x1/x5 and rd x0 (return)
- `r_pred_taken` in 1, `r_pred_target` in XLEN — prediction carried down the pipe for this instruction
- `flush` out 1 — mispredict, registered
- `redirect_pc` out XLEN — correct next PC, valid while `flush`=1

## Operation
- Index = `pc[IW+1:2]`; tag = `pc[IW+TAG_W+1:IW+2]`. Entry: valid, tag, target[XLEN-1:2], ctr[1:0], is_ret.
- Lookup: hit = valid && tag match. Predict taken iff hit && `ctr[1]`. Not taken → `p_target = f_pc+4`.
- Resolve (`r_valid` && `r_type`≠00): actual = `r_taken` for branch, 1 for jal/jalr.
  - Hit: branch → ctr saturating ±1 (11 max, 00 min); jal/jalr → ctr=11. Target, is_ret rewritten.
  - Miss and actual taken → allocate/overwrite: valid=1, new tag, target, ctr=10 (jal/jalr: 11), is_ret=`r_ret`.
  - Miss and not taken → no write.
- Mispredict = (`r_pred_taken` ≠ actual) || (actual && `r_pred_target` ≠ `r_target`). Next cycle: `flush`=1, `redirect_pc` = actual ? `r_target` : `r_pc+4`. Otherwise `flush`=0.
- Same-index lookup and update in one cycle: lookup uses pre-update contents (read-before-write).
- Reset: all valid=0, ctr=01, is_ret=0; `p_valid`, `p_taken`, `flush`=0; `p_target`, `redirect_pc`=0; RAS pointer=0, entries=0.
- Reset mid-operation: state cleared immediately (asynchronous); pending flush dropped.
- Arithmetic: all PC adds modulo 2^XLEN (wrap at 0xFFFF_FFFC+4 → 0).

## Timing
- Lookup latency 1: `f_valid` at edge N → `p_*` valid after edge N+1. `f_valid`=0 → `p_valid`=0 next cycle.
- `stall`=1: `p_*` registers hold; BTB updates and flush logic continue regardless of stall.
- Resolve-to-flush latency 1; `flush` is a one-cycle pulse per mispredicting resolve. Back-to-back mispredicts give consecutive pulses.
- BTB update visible to lookups issued on the cycle after the resolve edge.

## Configuration
- `RAS_PREDICT_EN` defined: `RAS_DEPTH`-entry return stack. Resolve with `r_link` pushes `r_pc+4`; resolve with `r_ret` pops; both set → pop then push. Lookup hit on an is_ret entry predicts taken with `p_target` = RAS top. Overflow wraps, overwriting the oldest entry. Pop when empty leaves the pointer at 0 and returns the stale top.
- Not defined: no RAS logic. is_ret is ignored. Returns predict the stored BTB target.

## Test plan
- Reset, then lookup `f_pc`=0x100 → next cycle `p_valid`=1, `p_taken`=0, `p_target`=0x104.
- Resolve branch `r_pc`=0x100, taken, target 0x80, `r_pred_taken`=0 → `flush`=1, `redirect_pc`=0x80. Then lookup 0x100 → taken, 0x80.
- Same branch resolved not-taken twice → ctr 10→01→00; lookup 0x100 predicts 0x104. Second resolve flushes with `redirect_pc`=0x104.
- Aliasing: entry at 0x100, lookup 0x100+4·BTB_ENTRIES·2^TAG_W → hit (tag alias). Lookup 0x100+4·BTB_ENTRIES → miss, predicts +4.
- Lookup and update to the same index in one cycle → prediction shows old contents. `stall`=1 holds `p_*` for 3 cycles.
- `RAS_PREDICT_EN`: jal call at 0x200 (`r_link`), then resolved return jalr at 0x300 (`r_ret`) → lookup 0x300 predicts 0x204. Push 5 calls with `RAS_DEPTH`=4 → oldest lost, pops return the last 4 in LIFO order.
